// File: rtl/axi_decerr_slave_if.sv
// AXI subset seen by the default (decode-error) slave: AW/W/B write path and AR/R read path.
// Signal names keep the slave-side _i/_o suffixes used throughout the crossbar.
interface axi_decerr_slave_if #(
  parameter int unsigned IdWidth   = 5,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64
);
  logic                 aw_valid_i;
  logic                 aw_ready_o;
  logic [IdWidth-1:0]   aw_id_i;
  logic [AddrWidth-1:0] aw_addr_i;
  logic                 w_valid_i;
  logic                 w_ready_o;
  logic                 w_last_i;
  logic                 b_valid_o;
  logic                 b_ready_i;
  logic [IdWidth-1:0]   b_id_o;
  logic [1:0]           b_resp_o;
  logic                 ar_valid_i;
  logic                 ar_ready_o;
  logic [IdWidth-1:0]   ar_id_i;
  logic [AddrWidth-1:0] ar_addr_i;
  logic [7:0]           ar_len_i;
  logic                 r_valid_o;
  logic                 r_ready_i;
  logic [IdWidth-1:0]   r_id_o;
  logic [DataWidth-1:0] r_data_o;
  logic [1:0]           r_resp_o;
  logic                 r_last_o;

  modport slave (
    input  aw_valid_i, aw_id_i, aw_addr_i, w_valid_i, w_last_i, b_ready_i,
           ar_valid_i, ar_id_i, ar_addr_i, ar_len_i, r_ready_i,
    output aw_ready_o, w_ready_o, b_valid_o, b_id_o, b_resp_o,
           ar_ready_o, r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o
  );

  modport master (
    output aw_valid_i, aw_id_i, aw_addr_i, w_valid_i, w_last_i, b_ready_i,
           ar_valid_i, ar_id_i, ar_addr_i, ar_len_i, r_ready_i,
    input  aw_ready_o, w_ready_o, b_valid_o, b_id_o, b_resp_o,
           ar_ready_o, r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o
  );
endinterface

// File: rtl/axi_decerr_slave.sv
// Crossbar fall-through slave: drains any unmapped AXI request and answers DECERR,
// while logging the last faulting address and a saturating fault count.
module axi_decerr_slave #(
  parameter int unsigned          IdWidth   = 5,
  parameter int unsigned          AddrWidth = 64,
  parameter int unsigned          DataWidth = 64,
  parameter int unsigned          CntWidth  = 16,
  parameter logic [DataWidth-1:0] RespData  = DataWidth'(64'hBADC_AB1E_BADC_AB1E)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  axi_decerr_slave_if.slave    bus,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic                 err_is_write_o,
  output logic [CntWidth-1:0]  err_count_o
);

  localparam logic [1:0] RespDecErr = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  w_state_e             w_state;
  r_state_e             r_state;
  logic                 aw_ready_q, w_ready_q, b_valid_q;
  logic                 ar_ready_q, r_valid_q, r_last_q;
  logic [IdWidth-1:0]   b_id_q, r_id_q;
  logic [7:0]           r_cnt_q;
  logic [AddrWidth-1:0] err_addr_q;
  logic                 err_is_write_q;
  logic [CntWidth-1:0]  err_cnt_q;

  logic                 aw_hs, ar_hs;
  logic [1:0]           n_faults;
  logic [CntWidth:0]    cnt_sum;

  assign aw_hs = bus.aw_valid_i && aw_ready_q;
  assign ar_hs = bus.ar_valid_i && ar_ready_q;

  // Write path: accept AW, swallow W beats up to w_last, then hold B until taken.
  // NOTE: every sequential block uses non-blocking assignments so all state
  // updates see the same pre-edge values, whatever order the blocks run in.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_state    <= W_IDLE;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_id_q     <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: if (aw_hs) begin
          b_id_q     <= bus.aw_id_i;
          aw_ready_q <= 1'b0;
          w_ready_q  <= 1'b1;
          w_state    <= W_DATA;
        end
        W_DATA: if (bus.w_valid_i && bus.w_last_i) begin
          w_ready_q <= 1'b0;
          b_valid_q <= 1'b1;
          w_state   <= W_RESP;
        end
        W_RESP: if (bus.b_ready_i) begin
          b_valid_q  <= 1'b0;
          aw_ready_q <= 1'b1;
          w_state    <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read path: r_cnt_q holds beats remaining after the one on the bus; r_last_q
  // is precomputed so it is registered and stays stable while stalled.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= R_IDLE;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_id_q     <= '0;
      r_cnt_q    <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: if (ar_hs) begin
          r_id_q     <= bus.ar_id_i;
          r_cnt_q    <= bus.ar_len_i;
          r_last_q   <= (bus.ar_len_i == 8'd0);
          ar_ready_q <= 1'b0;
          r_valid_q  <= 1'b1;
          r_state    <= R_DATA;
        end
        R_DATA: if (bus.r_ready_i) begin
          if (r_last_q) begin
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            ar_ready_q <= 1'b1;
            r_state    <= R_IDLE;
          end else begin
            r_cnt_q  <= r_cnt_q - 8'd1;
            r_last_q <= (r_cnt_q == 8'd1);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // NOTE: every always_comb output gets a value before any condition, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    n_faults = 2'd0;
    cnt_sum  = '0;
    n_faults = {1'b0, aw_hs} + {1'b0, ar_hs};
    cnt_sum  = {1'b0, err_cnt_q} + (CntWidth + 1)'(n_faults);
  end

  // A write wins the address log when both channels fault in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_addr_q     <= '0;
      err_is_write_q <= 1'b0;
      err_cnt_q      <= '0;
    end else begin
      if (aw_hs) begin
        err_addr_q     <= bus.aw_addr_i;
        err_is_write_q <= 1'b1;
      end else if (ar_hs) begin
        err_addr_q     <= bus.ar_addr_i;
        err_is_write_q <= 1'b0;
      end
      err_cnt_q <= cnt_sum[CntWidth] ? '1 : cnt_sum[CntWidth-1:0];
    end
  end

  assign bus.aw_ready_o = aw_ready_q;
  assign bus.w_ready_o  = w_ready_q;
  assign bus.b_valid_o  = b_valid_q;
  assign bus.b_id_o     = b_id_q;
  assign bus.b_resp_o   = RespDecErr;
  assign bus.ar_ready_o = ar_ready_q;
  assign bus.r_valid_o  = r_valid_q;
  assign bus.r_id_o     = r_id_q;
  assign bus.r_data_o   = RespData;
  assign bus.r_resp_o   = RespDecErr;
  assign bus.r_last_o   = r_last_q;

  assign err_addr_o     = err_addr_q;
  assign err_is_write_o = err_is_write_q;
  assign err_count_o    = err_cnt_q;

endmodule

// File: doc/axi_decerr_slave.md
Name: axi_decerr_slave

Overview:
- Default (fall-through) slave of the SoC AXI crossbar.
- Terminates every transaction whose address lies outside all mapped regions: Debug, ROM, CLINT, PLIC, UART, Timer, SPI, Ethernet, GPIO and DRAM.
- Accepts and drains full bursts and answers with DECERR, so the core sees a bus error instead of a hang.
- Logs the last offending address and keeps a count of faults for debug.

Parameters:
- IdWidth, 5, slave-side AXI ID width (master IdWidth 4 + clog2 of 2 crossbar masters).
- AddrWidth, 64, AXI address width.
- DataWidth, 64, AXI data width.
- CntWidth, 16, error counter width.
- RespData, 64'hBADC_AB1E_BADC_AB1E, constant returned on R data.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- aw_valid_i  in  1  write address valid
- aw_ready_o  out  1  write address ready
- aw_id_i  in  IdWidth  write ID
- aw_addr_i  in  AddrWidth  write address
- w_valid_i  in  1  write data valid
- w_ready_o  out  1  write data ready
- w_last_i  in  1  last write beat
- b_valid_o  out  1  write response valid
- b_ready_i  in  1  write response ready
- b_id_o  out  IdWidth  response ID
- b_resp_o  out  2  always 2'b11 (DECERR)
- ar_valid_i  in  1  read address valid
- ar_ready_o  out  1  read address ready
- ar_id_i  in  IdWidth  read ID
- ar_addr_i  in  AddrWidth  read address
- ar_len_i  in  8  burst length minus 1
- r_valid_o  out  1  read data valid
- r_ready_i  in  1  read data ready
- r_id_o  out  IdWidth  read ID
- r_data_o  out  DataWidth  RespData
- r_resp_o  out  2  always 2'b11
- r_last_o  out  1  final read beat
- err_addr_o  out  AddrWidth  address of most recent faulting request
- err_is_write_o  out  1  1 if most recent fault was a write
- err_count_o  out  CntWidth  saturating fault count

Behaviour:
- All state updates on rising clk_i. rst_ni low at a clock edge resets all state, including mid-burst; partially drained bursts are abandoned.
- Reset values:
  - both FSMs IDLE;
  - aw_ready_o=1, ar_ready_o=1;
  - w_ready_o, b_valid_o, r_valid_o, r_last_o = 0;
  - ids, err_addr_o, err_is_write_o, err_count_o = 0.
- Write FSM, independent of read:
  - W_IDLE: aw_ready_o=1. AW handshake latches aw_id_i and moves to W_DATA.
  - W_DATA: w_ready_o=1, aw_ready_o=0. Every W beat is accepted and discarded. A W handshake with w_last_i=1 moves to W_RESP. W beats in W_IDLE are not accepted (w_ready_o=0).
  - W_RESP: b_valid_o=1, b_id_o=latched id. It holds stable until b_ready_i; the handshake returns to W_IDLE.
  - Minimum write turnaround is 3 cycles: AW, then single W, then B.
- Read FSM:
  - R_IDLE: ar_ready_o=1. AR handshake latches id and beat counter = ar_len_i, then moves to R_DATA.
  - R_DATA: r_valid_o=1, ar_ready_o=0. r_last_o=1 when counter==0. Each R handshake decrements the counter. The handshake with r_last_o returns to R_IDLE.
  - ar_len_i=255 yields 256 beats; the counter never wraps below 0.
  - Outputs stay stable while r_valid_o && !r_ready_i.
- Read and write FSMs run fully concurrently; no ordering between them.
- Error log:
  - On each AW or AR handshake, err_addr_o/err_is_write_o update the next cycle.
  - On a simultaneous AW and AR handshake, the write is logged, and err_count_o increments by 2.
  - err_count_o saturates at 2^CntWidth-1; it never wraps.
- Each channel accepts one outstanding transaction at a time; no ID reordering concerns.

Test Plan:
- Single write: AW id=5'h13 addr=64'h5000_0000, one W with last, b_ready=1 → b_valid on cycle 3, b_id=5'h13, b_resp=2'b11, err_addr=64'h5000_0000, err_is_write=1, count=1.
- Read burst: AR id=5'h02 addr=64'h6000_0010 len=3, r_ready=1 → exactly 4 beats of r_data=64'hBADC_AB1E_BADC_AB1E, r_resp=2'b11, r_last only on beat 4, ar_ready back to 1 the cycle after.
- Backpressure: len=1 read with r_ready toggled 0/1, and b_ready held 0 for 10 cycles → r_* and b_* stay stable while stalled; no beat lost or duplicated.
- Concurrency: AW and AR handshake in the same cycle at 64'h7000_0000 / 64'h7000_1000 → both complete, err_addr=64'h7000_0000, err_is_write=1, count +=2.
- Long burst plus reset: AR len=255, assert rst_ni=0 after beat 100 → next cycle r_valid=0, ar_ready=1, count=0; a fresh len=0 read returns a single beat with r_last=1.
- Saturation: CntWidth=2, 5 faulting writes → err_count_o sticks at 3.
